// File: rtl/output_driver_bank_if.sv
// output_driver_bank_if: register-bus signals that configure the output driver bank.
// The master drives staged-register writes; the slave is the driver bank.
interface output_driver_bank_if;
    logic        csrWrite;
    logic [4:0]  csrChannel;
    logic [2:0]  csrOp;
    logic [31:0] csrData;

    modport master (output csrWrite, csrChannel, csrOp, csrData);
    modport slave  (input  csrWrite, csrChannel, csrOp, csrData);
endinterface

// File: rtl/output_driver_bank.sv
// output_driver_bank: NCHAN independent pulse generators producing SERDES_WIDTH-bit words
// per evrClk cycle, with staged configuration committed atomically while a channel is idle.
// Burst mode (PERIOD/COUNT registers and the GAP state) is built only when
// OUTPUT_DRIVER_BANK_BURST_EN is defined.
module output_driver_bank #(
    parameter int unsigned NCHAN              = 4,
    parameter int unsigned SERDES_WIDTH       = 4,
    parameter int unsigned COARSE_DELAY_WIDTH = 22,
    parameter int unsigned COARSE_WIDTH_WIDTH = 20,
    parameter int unsigned PERIOD_WIDTH       = 24,
    parameter int unsigned COUNT_WIDTH        = 16
) (
    input  logic                          evrClk,
    input  logic                          evrReset_n,
    output_driver_bank_if.slave           csr,
    input  logic [NCHAN-1:0]              triggerStrobe,
    output logic [NCHAN*SERDES_WIDTH-1:0] serdesPattern,
    output logic [NCHAN-1:0]              busy,
    output logic [NCHAN-1:0]              triggerOverrun
);
    localparam int unsigned SW   = SERDES_WIDTH;
    localparam int unsigned DW   = COARSE_DELAY_WIDTH;
    localparam int unsigned WW   = COARSE_WIDTH_WIDTH;
    localparam int unsigned CntA = (DW > WW) ? DW : WW;
    localparam logic [1:0] ModePulse = 2'd1;
`ifdef OUTPUT_DRIVER_BANK_BURST_EN
    // Wide enough for both P and W+2 so the effective period never wraps.
    localparam int unsigned GapW = (PERIOD_WIDTH > WW + 1) ? PERIOD_WIDTH : WW + 1;
    localparam int unsigned CntW = (CntA > GapW) ? CntA : GapW;
    localparam logic [1:0] ModeBurst = 2'd2;
    typedef enum logic [1:0] {StIdle, StDelay, StPulse, StGap} stateT;
`else
    localparam int unsigned CntW = CntA;
    typedef enum logic [1:0] {StIdle, StDelay, StPulse} stateT;
`endif

    // Upper data bits beyond the packed fields carry nothing.
    logic unusedCsrData;
    assign unusedCsrData = ^csr.csrData;

    for (genvar c = 0; c < NCHAN; c++) begin : gChan
        logic          wrSel;
        logic          commitPendingQ;
        logic          commitNow;
        logic          trigAccept;
        logic [1:0]    stModeQ, actModeQ, effMode;
        logic [DW-1:0] stDelayQ, actDelayQ, effDelay;
        logic [WW-1:0] stWidthQ, actWidthQ;
        logic [SW-1:0] stFirstQ, actFirstQ, stLastQ, actLastQ;
        stateT         stateQ;
        logic [CntW-1:0] cntQ;
        logic [SW-1:0] patternQ;
        logic          busyQ;
        logic          overrunQ;
`ifdef OUTPUT_DRIVER_BANK_BURST_EN
        logic [PERIOD_WIDTH-1:0] stPeriodQ, actPeriodQ;
        logic [COUNT_WIDTH-1:0]  stCountQ, actCountQ, effCount, pulsesLeftQ;
        logic [GapW-1:0]         widthPlus2, periodExt, effPeriod;

        assign effCount   = commitNow ? stCountQ : actCountQ;
        assign widthPlus2 = GapW'(actWidthQ) + GapW'(2);
        assign periodExt  = GapW'(actPeriodQ);
        assign effPeriod  = (periodExt > widthPlus2) ? periodExt : widthPlus2;
        assign trigAccept = (effMode == ModePulse) || (effMode == ModeBurst);
`else
        assign trigAccept = (effMode == ModePulse);
`endif

        assign wrSel     = csr.csrWrite && (csr.csrChannel == 5'(c));
        assign commitNow = commitPendingQ && (stateQ == StIdle);
        // A commit landing with a trigger must feed the new parameters to that trigger.
        assign effMode   = commitNow ? stModeQ  : actModeQ;
        assign effDelay  = commitNow ? stDelayQ : actDelayQ;

        // Staged register writes; a MODE write arms the commit.
        always_ff @(posedge evrClk or negedge evrReset_n) begin
            if (!evrReset_n) begin
                stModeQ        <= '0;
                stDelayQ       <= '0;
                stWidthQ       <= '0;
                stFirstQ       <= '0;
                stLastQ        <= '0;
                commitPendingQ <= 1'b0;
`ifdef OUTPUT_DRIVER_BANK_BURST_EN
                stPeriodQ      <= '0;
                stCountQ       <= COUNT_WIDTH'(1);
`endif
            end else begin
                if (wrSel) begin
                    case (csr.csrOp)
                        3'd0: stModeQ <= csr.csrData[1:0];
                        3'd1: begin
                            stDelayQ <= csr.csrData[SW +: DW];
                            stFirstQ <= csr.csrData[SW-1:0];
                        end
                        3'd2: begin
                            stWidthQ <= csr.csrData[SW +: WW];
                            stLastQ  <= csr.csrData[SW-1:0];
                        end
`ifdef OUTPUT_DRIVER_BANK_BURST_EN
                        3'd3: stPeriodQ <= csr.csrData[PERIOD_WIDTH-1:0];
                        3'd4: stCountQ  <= csr.csrData[COUNT_WIDTH-1:0];
`endif
                        default: ;
                    endcase
                end
                if (wrSel && (csr.csrOp == 3'd0)) begin
                    commitPendingQ <= 1'b1;
                end else if (commitNow) begin
                    commitPendingQ <= 1'b0;
                end
            end
        end

        // Channel sequencer: active-set commit, pulse timing and registered outputs.
        always_ff @(posedge evrClk or negedge evrReset_n) begin
            if (!evrReset_n) begin
                stateQ     <= StIdle;
                cntQ       <= '0;
                patternQ   <= '0;
                busyQ      <= 1'b0;
                overrunQ   <= 1'b0;
                actModeQ   <= '0;
                actDelayQ  <= '0;
                actWidthQ  <= '0;
                actFirstQ  <= '0;
                actLastQ   <= '0;
`ifdef OUTPUT_DRIVER_BANK_BURST_EN
                actPeriodQ  <= '0;
                actCountQ   <= COUNT_WIDTH'(1);
                pulsesLeftQ <= '0;
`endif
            end else begin
                patternQ <= '0;
                overrunQ <= (stateQ != StIdle) && triggerStrobe[c];
                unique case (stateQ)
                    StIdle: begin
                        if (commitNow) begin
                            actModeQ  <= stModeQ;
                            actDelayQ <= stDelayQ;
                            actWidthQ <= stWidthQ;
                            actFirstQ <= stFirstQ;
                            actLastQ  <= stLastQ;
`ifdef OUTPUT_DRIVER_BANK_BURST_EN
                            actPeriodQ <= stPeriodQ;
                            actCountQ  <= stCountQ;
`endif
                        end
                        busyQ <= triggerStrobe[c] && trigAccept;
                        if (triggerStrobe[c] && trigAccept) begin
                            stateQ <= StDelay;
                            cntQ   <= CntW'(effDelay);
`ifdef OUTPUT_DRIVER_BANK_BURST_EN
                            // Extra pulses after the first; N=0 counts as one pulse.
                            pulsesLeftQ <= (effCount == '0) ? '0 : effCount - COUNT_WIDTH'(1);
`endif
                        end
                    end
                    StDelay: begin
                        if (cntQ == '0) begin
                            patternQ <= actFirstQ;
                            cntQ     <= CntW'(actWidthQ);
                            stateQ   <= StPulse;
                        end else begin
                            cntQ <= cntQ - CntW'(1);
                        end
                    end
                    StPulse: begin
                        if (cntQ == '0) begin
                            // busyQ stays high through this edge and drops in IDLE.
                            patternQ <= actLastQ;
                            stateQ   <= StIdle;
`ifdef OUTPUT_DRIVER_BANK_BURST_EN
                            if ((actModeQ == ModeBurst) && (pulsesLeftQ != '0)) begin
                                stateQ      <= StGap;
                                pulsesLeftQ <= pulsesLeftQ - COUNT_WIDTH'(1);
                                cntQ        <= CntW'(effPeriod - widthPlus2);
                            end
`endif
                        end else begin
                            patternQ <= '1;
                            cntQ     <= cntQ - CntW'(1);
                        end
                    end
`ifdef OUTPUT_DRIVER_BANK_BURST_EN
                    StGap: begin
                        if (cntQ == '0) begin
                            patternQ <= actFirstQ;
                            cntQ     <= CntW'(actWidthQ);
                            stateQ   <= StPulse;
                        end else begin
                            cntQ <= cntQ - CntW'(1);
                        end
                    end
`endif
                    default: stateQ <= StIdle;
                endcase
            end
        end

        assign serdesPattern[c*SW +: SW] = patternQ;
        assign busy[c]                   = busyQ;
        assign triggerOverrun[c]         = overrunQ;
    end
endmodule

// File: tb/tb_output_driver_bank.sv
// tb_output_driver_bank: table-driven pulse/burst vectors checked through an expected-word
// queue, plus hand-written sequences for overrun, re-trigger, staged commit and reset.
module tb_output_driver_bank;
    localparam int unsigned NCHAN = 4;
    localparam int unsigned SW    = 4;

    logic                  evrClk = 1'b0;
    logic                  evrReset_n;
    logic [NCHAN-1:0]      triggerStrobe;
    logic [NCHAN*SW-1:0]   serdesPattern;
    logic [NCHAN-1:0]      busy;
    logic [NCHAN-1:0]      triggerOverrun;

    output_driver_bank_if bus ();

    output_driver_bank #(
        .NCHAN        (NCHAN),
        .SERDES_WIDTH (SW)
    ) dut (
        .evrClk         (evrClk),
        .evrReset_n     (evrReset_n),
        .csr            (bus),
        .triggerStrobe  (triggerStrobe),
        .serdesPattern  (serdesPattern),
        .busy           (busy),
        .triggerOverrun (triggerOverrun)
    );

    always #5 evrClk = ~evrClk;

    typedef struct {
        int          ch;
        int          mode;
        int          d;
        int          w;
        logic [3:0]  first;
        logic [3:0]  last;
        int          p;
        int          n;
        string       name;
    } vecT;

    typedef struct {
        int          ch;
        logic [3:0]  pat;
        logic        busy;
        logic        ovr;
        string       name;
    } expT;

    vecT vecs[$];
    expT expQ[$];
    int  nCompared;
    int  nMismatched;

    function automatic vecT mk(input int ch, input int mode, input int d, input int w,
                               input logic [3:0] first, input logic [3:0] last,
                               input int p, input int n, input string name);
        vecT v;
        v.ch = ch; v.mode = mode; v.d = d; v.w = w;
        v.first = first; v.last = last; v.p = p; v.n = n; v.name = name;
        return v;
    endfunction

    task automatic tick();
        @(posedge evrClk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic writeCsr(input int ch, input int op, input logic [31:0] data);
        bus.csrWrite   = 1'b1;
        bus.csrChannel = 5'(ch);
        bus.csrOp      = 3'(op);
        bus.csrData    = data;
        tick();
        bus.csrWrite   = 1'b0;
    endtask

    task automatic pushExp(input int ch, input logic [3:0] pat, input logic b, input logic o,
                           input string name);
        expT e;
        e.ch = ch; e.pat = pat; e.busy = b; e.ovr = o; e.name = name;
        expQ.push_back(e);
    endtask

    // Reference waveform from the edge formulas: pulse n starts at E(D+1+n*Pe).
    task automatic pushWave(input int ch, input int d, input int w, input logic [3:0] first,
                            input logic [3:0] last, input int pe, input int n,
                            input string name);
        int lastEdge;
        lastEdge = d + 2 + w + (n - 1) * pe;
        for (int k = 0; k <= lastEdge + 1; k++) begin
            logic [3:0] pat;
            pat = 4'b0000;
            for (int i = 0; i < n; i++) begin
                int base;
                base = d + 1 + i * pe;
                if (k == base) pat = first;
                else if (k > base && k <= base + w) pat = 4'b1111;
                else if (k == base + w + 1) pat = last;
            end
            pushExp(ch, pat, (k <= lastEdge), 1'b0, $sformatf("%s E%0d", name, k));
        end
    endtask

    task automatic popCompare();
        expT e;
        e = expQ.pop_front();
        check({e.name, " pattern"}, 32'(serdesPattern[e.ch*SW +: SW]), 32'(e.pat));
        check({e.name, " busy"}, 32'(busy[e.ch]), 32'(e.busy));
        check({e.name, " overrun"}, 32'(triggerOverrun[e.ch]), 32'(e.ovr));
    endtask

    task automatic drain();
        while (expQ.size() > 0) begin
            tick();
            popCompare();
        end
    endtask

    task automatic fire(input int ch);
        triggerStrobe[ch] = 1'b1;
        tick();
        triggerStrobe = '0;
        popCompare();
        drain();
    endtask

    task automatic configure(input vecT v);
        writeCsr(v.ch, 1, (32'(v.d) << SW) | 32'(v.first));
        writeCsr(v.ch, 2, (32'(v.w) << SW) | 32'(v.last));
`ifdef OUTPUT_DRIVER_BANK_BURST_EN
        writeCsr(v.ch, 3, 32'(v.p));
        writeCsr(v.ch, 4, 32'(v.n));
`endif
        writeCsr(v.ch, 0, 32'(v.mode));
    endtask

    task automatic checkAllQuiet(input string name);
        check({name, " pattern"}, 32'(serdesPattern), 32'd0);
        check({name, " busy"}, 32'(busy), 32'd0);
        check({name, " overrun"}, 32'(triggerOverrun), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecT v;
        int  nEff;
        int  pe;
        int  len;

        nCompared   = 0;
        nMismatched = 0;

        vecs.push_back(mk(0, 1, 3, 2, 4'b1100, 4'b0011, 0, 1, "ch0_pulse_d3w2"));
        vecs.push_back(mk(1, 1, 0, 0, 4'b1000, 4'b0001, 0, 1, "ch1_pulse_d0w0"));
        vecs.push_back(mk(2, 1, 1, 5, 4'b1010, 4'b0101, 0, 1, "ch2_pulse_d1w5"));
        vecs.push_back(mk(3, 1, 7, 1, 4'b1110, 4'b0111, 4, 3, "ch3_pulse_ignores_count"));
`ifdef OUTPUT_DRIVER_BANK_BURST_EN
        vecs.push_back(mk(0, 2, 1, 1, 4'b1001, 4'b0110, 5, 3, "ch0_burst_p5n3"));
        vecs.push_back(mk(0, 2, 1, 1, 4'b1001, 4'b0110, 1, 3, "ch0_burst_p1n3"));
        vecs.push_back(mk(2, 2, 2, 3, 4'b1100, 4'b0011, 0, 0, "ch2_burst_n0"));
`endif

        evrReset_n     = 1'b0;
        triggerStrobe  = '0;
        bus.csrWrite   = 1'b0;
        bus.csrChannel = '0;
        bus.csrOp      = '0;
        bus.csrData    = '0;
        tick();
        tick();
        checkAllQuiet("reset_state");
        @(negedge evrClk);
        evrReset_n = 1'b1;
        tick();
        checkAllQuiet("after_reset_release");

        // Table: configure, trigger on the commit edge, compare every word to idle.
        foreach (vecs[i]) begin
            v    = vecs[i];
            nEff = (v.mode == 2) ? ((v.n == 0) ? 1 : v.n) : 1;
            pe   = (v.p > v.w + 2) ? v.p : v.w + 2;
            configure(v);
            pushWave(v.ch, v.d, v.w, v.first, v.last, pe, nEff, v.name);
            fire(v.ch);
        end

        // Ch1 D=0 W=0: second trigger at E1 overruns, trigger at E3 is accepted.
        pushExp(1, 4'b0000, 1'b1, 1'b0, "retrig E0");
        pushExp(1, 4'b1000, 1'b1, 1'b1, "retrig E1");
        pushExp(1, 4'b0001, 1'b1, 1'b0, "retrig E2");
        pushExp(1, 4'b0000, 1'b1, 1'b0, "retrig E3");
        pushExp(1, 4'b1000, 1'b1, 1'b0, "retrig E4");
        pushExp(1, 4'b0001, 1'b1, 1'b0, "retrig E5");
        pushExp(1, 4'b0000, 1'b0, 1'b0, "retrig E6");
        for (int k = 0; k < 7; k++) begin
            triggerStrobe[1] = (k == 0) || (k == 1) || (k == 3);
            tick();
            popCompare();
        end
        triggerStrobe = '0;

        // Writes to channels beyond NCHAN must not alias onto real channels.
        writeCsr(4, 0, 32'd0);
        writeCsr(5, 1, 32'h0000_00F0);
        writeCsr(5, 0, 32'd0);
        pushWave(1, 0, 0, 4'b1000, 4'b0001, 2, 1, "ch_out_of_range");
        fire(1);

        // Ch3 D=7: stage D=6 and commit mid-pulse; current pulse keeps D=7.
        pushWave(3, 7, 1, 4'b1110, 4'b0111, 3, 1, "staged_midpulse_old");
        len = expQ.size();
        for (int k = 0; k < len; k++) begin
            triggerStrobe[3] = (k == 0);
            if (k == 1) begin
                bus.csrWrite = 1'b1; bus.csrChannel = 5'd3; bus.csrOp = 3'd1;
                bus.csrData  = (32'd6 << SW) | 32'hE;
            end else if (k == 2) begin
                bus.csrWrite = 1'b1; bus.csrChannel = 5'd3; bus.csrOp = 3'd0;
                bus.csrData  = 32'd1;
            end else begin
                bus.csrWrite = 1'b0;
            end
            tick();
            popCompare();
        end
        bus.csrWrite  = 1'b0;
        triggerStrobe = '0;
        pushWave(3, 6, 1, 4'b1110, 4'b0111, 3, 1, "staged_next_trigger");
        fire(3);

        // Reset mid-PULSE on ch2 while ch3 sits in DELAY.
        configure(mk(2, 1, 1, 5, 4'b1010, 4'b0101, 0, 1, "ch2_reset"));
        triggerStrobe = 4'b1100;
        tick();
        triggerStrobe = '0;
        tick();
        tick();
        tick();
        check("pre_reset ch2 pattern", 32'(serdesPattern[2*SW +: SW]), 32'hF);
        check("pre_reset ch3 busy", 32'(busy[3]), 32'd1);
        check("pre_reset ch3 pattern", 32'(serdesPattern[3*SW +: SW]), 32'd0);
        #2;
        evrReset_n = 1'b0;
        #1;
        checkAllQuiet("async_reset");
        @(negedge evrClk);
        evrReset_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            triggerStrobe = (k == 0) ? 4'b1100 : ((k == 1) ? 4'b0100 : 4'b0000);
            tick();
            checkAllQuiet($sformatf("post_reset_disabled E%0d", k));
        end
        triggerStrobe = '0;

`ifndef OUTPUT_DRIVER_BANK_BURST_EN
        // Without burst support MODE=2 behaves as disabled.
        writeCsr(0, 0, 32'd2);
        for (int k = 0; k < 6; k++) begin
            triggerStrobe[0] = (k == 0) || (k == 2);
            tick();
            check($sformatf("mode2_disabled E%0d pattern", k), 32'(serdesPattern[SW-1:0]), 32'd0);
            check($sformatf("mode2_disabled E%0d busy", k), 32'(busy[0]), 32'd0);
            check($sformatf("mode2_disabled E%0d overrun", k), 32'(triggerOverrun[0]), 32'd0);
        end
        triggerStrobe = '0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end
endmodule
